rv32m_seq_muldiv: RTL and testbench

Iterative RV32M multiply/divide responder that serves the EX stage's `start`/`busy`/`valid` request interface. It accepts one operation per request and computes all eight M-extension functions, selected by funct3. It uses a radix-2 shift-add multiplier and a restoring divider with a shared XLEN-cycle iteration counter. Divide-by-zero and signed-overflow cases bypass the iterations.

---
 rtl/rv32m_seq_muldiv.sv | 169 ++++++++++++++++
 tb/tb_rv32m_seq_muldiv.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_seq_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one accumulator and iteration counter; b==0 and signed overflow skip CALC.
module rv32m_seq_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            valid
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] L_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] L_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] L_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_busy, r_valid, w_busy_nxt, w_valid_nxt;
    logic [2:0]          r_op;
    logic                r_sa, r_sb;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    logic [XLEN-1:0]     r_result;

    logic                w_accept, w_sa, w_sb, w_b_zero, w_ovf, w_fast;
    logic [XLEN-1:0]     w_mag_a, w_mag_b, w_fast_result, w_final;
    logic [XLEN:0]       w_sum, w_trial, w_diff;
    logic [2*XLEN-1:0]   w_shift, w_iter, w_prod;

    function automatic logic [XLEN-1:0] f_neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] f_neg2_if(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? (~v + (2*XLEN)'(1)) : v;
    endfunction

    assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    // MULHSU treats only rs1 as signed; DIVU/REMU/MULHU/MUL are magnitude-only
    assign w_sa     = ((op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110)) & a[XLEN-1];
    assign w_sb     = ((op == 3'b001) | (op == 3'b100) | (op == 3'b110)) & b[XLEN-1];
    assign w_mag_a  = f_neg_if(w_sa, a);
    assign w_mag_b  = f_neg_if(w_sb, b);
    assign w_b_zero = (b == L_ZERO);
    assign w_ovf    = ~op[0] & (a == L_MIN) & (b == L_ONES);
    assign w_fast   = op[2] & (w_b_zero | w_ovf);

    // Immediate result for divide-by-zero and signed overflow
    always_comb begin
        if (w_b_zero) begin
            w_fast_result = op[1] ? a : L_ONES;
        end else begin
            w_fast_result = op[1] ? L_ZERO : L_MIN;
        end
    end

    // One iteration: multiply adds multiplicand into the high half then shifts right;
    // divide shifts {rem,quo} left with the bit shifted out of rem kept for the trial compare
    always_comb begin
        w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_shift = {r_acc[2*XLEN-2:0], 1'b0};
        w_trial = r_acc[2*XLEN-1:XLEN-1];
        w_diff  = w_trial - {1'b0, r_opnd};
        if (r_op[2]) begin
            if (w_trial >= {1'b0, r_opnd}) begin
                w_iter = {w_diff[XLEN-1:0], w_shift[XLEN-1:1], 1'b1};
            end else begin
                w_iter = w_shift;
            end
        end else begin
            w_iter = {w_sum, r_acc[XLEN-1:1]};
        end
    end

    // Sign correction applied to the last iteration's output, so DONE needs no extra cycle
    always_comb begin
        w_prod = f_neg2_if(r_sa ^ r_sb, w_iter);
        case (r_op)
            3'b000:  w_final = w_prod[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  w_final = w_prod[2*XLEN-1:XLEN];
            3'b100:  w_final = f_neg_if(r_sa ^ r_sb, w_iter[XLEN-1:0]);
            3'b101:  w_final = w_iter[XLEN-1:0];
            3'b110:  w_final = f_neg_if(r_sa, w_iter[2*XLEN-1:XLEN]);
            3'b111:  w_final = w_iter[2*XLEN-1:XLEN];
            default: w_final = L_ZERO;
        endcase
    end

    // State register with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        case (r_state)
            S_IDLE:  w_state_nxt = w_accept ? (w_fast ? S_DONE : S_CALC) : S_IDLE;
            S_CALC:  w_state_nxt = (r_cnt == {CW{1'b0}}) ? S_DONE : S_CALC;
            S_DONE:  w_state_nxt = w_accept ? (w_fast ? S_DONE : S_CALC) : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/valid are registered
    always_comb begin
        w_busy_nxt  = (w_state_nxt == S_CALC);
        w_valid_nxt = (w_state_nxt == S_DONE);
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= 3'b000;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_opnd   <= L_ZERO;
            r_result <= L_ZERO;
        end else if (w_accept) begin
            r_op  <= op;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_cnt <= CW'(XLEN - 1);
            if (op[2]) begin
                r_acc  <= {L_ZERO, w_mag_a};
                r_opnd <= w_mag_b;
            end else begin
                r_acc  <= {L_ZERO, w_mag_b};
                r_opnd <= w_mag_a;
            end
            if (w_fast) begin
                r_result <= w_fast_result;
            end else begin
                r_result <= r_result;
            end
        end else if (r_state == S_CALC) begin
            r_acc <= w_iter;
            if (r_cnt == {CW{1'b0}}) begin
                r_result <= w_final;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end else begin
            r_acc <= r_acc;
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign valid  = r_valid;
endmodule

// File: tb/tb_rv32m_seq_muldiv.sv
// Scoreboard bench for rv32m_seq_muldiv: driver pushes expected result and completion
// cycle, a negedge monitor checks busy window, valid timing, result and result hold.
module tb_rv32m_seq_muldiv;
    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] result;
    logic        busy, valid;

    rv32m_seq_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .busy(busy), .valid(valid)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          busy_lo = 1;
    int          busy_hi = 0;
    logic [31:0] hold = 32'h0;
    bit          mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model from the RV32M definitions, using 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        int sx, sy;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin p = {32'h0, x} * {32'h0, y}; return p[31:0]; end
            3'd1: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
            3'd2: begin p = {{32{x[31]}}, x} * {32'h0, y}; return p[63:32]; end
            3'd3: begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sx / sy;
            end
            3'd5: return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 32'h0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return sx % sy;
            end
            default: return (y == 32'h0) ? x : x % y;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp_res);
        exp_t e;
        bit   fast;
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        fast = o[2] && (y == 32'h0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
        e.res = exp_res;
        e.cyc = fast ? cyc : cyc + 32;
        q.push_back(e);
        if (!fast) begin
            busy_lo = cyc;
            busy_hi = cyc + 31;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (valid === 1'b1) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_done: valid got 0 required 1 within 40 cycles");
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp_res);
        issue(o, x, y, exp_res);
        wait_done();
        tick();
    endtask

    // Monitor: busy window, valid timing against scoreboard, result hold
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", {63'h0, busy}, {63'h0, (cyc >= busy_lo && cyc <= busy_hi)});
            if (valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_valid at cycle %0d: got valid 1 required 0", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("valid_cycle", 64'(e.cyc), 64'(cyc));
                    check("result", {32'h0, result}, {32'h0, e.res});
                    hold = e.res;
                end
            end else begin
                check("result_hold", {32'h0, result}, {32'h0, hold});
                if (q.size() > 0 && cyc > q[0].cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_valid at cycle %0d: got valid 0 required 1 at cycle %0d", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int e0;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
        repeat (3) tick();
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_valid", {63'h0, valid}, 64'h0);
        check("rst_result", {32'h0, result}, 64'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // MUL with ignored start pulses during CALC
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        repeat (4) tick();
        for (int i = 0; i < 16; i++) begin
            start = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            tick();
        end
        start = 1'b0;
        wait_done();
        tick();

        run(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run(3'd5, 32'd100, 32'd7, 32'h0000_000E);
        run(3'd7, 32'd100, 32'd7, 32'h0000_0002);
        run(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run(3'd7, 32'd5, 32'd0, 32'h0000_0005);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // Back-to-back: DIVU issued in the MULHU valid cycle
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));
        wait_done();
        issue(3'd5, 32'hDEAD_BEEF, 32'h0000_1234, ref_model(3'd5, 32'hDEAD_BEEF, 32'h0000_1234));
        wait_done();
        tick();

        // Reset during a DIV, then a fresh MUL
        issue(3'd4, 32'h7654_3210, 32'h0000_0013, 32'h0);
        e0 = cyc;
        while (cyc < e0 + 9) tick();
        rst = 1'b1;
        tick();
        q.delete();
        busy_lo = 1; busy_hi = 0; hold = 32'h0;
        check("rst_mid_busy", {63'h0, busy}, 64'h0);
        check("rst_mid_valid", {63'h0, valid}, 64'h0);
        check("rst_mid_result", {32'h0, result}, 64'h0);
        rst = 1'b0;
        tick();
        issue(3'd0, 32'd3, 32'd4, 32'h0000_000C);
        check("restart_cycle", 64'(cyc), 64'(e0 + 12));
        wait_done();
        tick();

        // Randomized operations, biased toward the fast-path corners
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'h0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = 32'($urandom_range(1, 255));
                default: ry = $urandom;
            endcase
            issue(ro, rx, ry, ref_model(ro, rx, ry));
            wait_done();
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();
        repeat (3) tick();
        check("queue_drained", 64'(q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
